// File: rtl/spram_arb.sv
// Single-port RAM shared by nPorts requesters through a round-robin arbiter.
// Byte-enabled writes, one access per clock, optional extra read output stage.
module spram_arb #(
  parameter int unsigned aWidth = 10,
  parameter int unsigned dWidth = 16,
  parameter int unsigned nPorts = 2,
  parameter int unsigned outReg = 0,
  parameter string       rStyle = "no_rw_check"
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [nPorts-1:0]              req,
  input  logic [nPorts-1:0]              we,
  input  logic [nPorts*aWidth-1:0]       addr,
  input  logic [nPorts*dWidth-1:0]       d,
  input  logic [nPorts*(dWidth/8)-1:0]   be,
  output logic [nPorts-1:0]              gnt,
  output logic [dWidth-1:0]              q,
  output logic [nPorts-1:0]              rvalid
);

  localparam int unsigned BeWidth  = dWidth / 8;
  localparam int unsigned IdxWidth = $clog2(nPorts);
  localparam int unsigned Depth    = 2 ** aWidth;

  (* ram_style = rStyle *) logic [dWidth-1:0] mem [Depth];

  logic [IdxWidth-1:0] last_grant;
  logic [IdxWidth-1:0] cand;
  logic [IdxWidth-1:0] gnt_idx;
  logic                gnt_any;
  logic [aWidth-1:0]   sel_addr;
  logic [dWidth-1:0]   sel_d;
  logic [BeWidth-1:0]  sel_be;
  logic                sel_we;
  logic                wr_en;
  logic                rd_en;
  logic [dWidth-1:0]   rd_data;
  logic [nPorts-1:0]   rd_tag;

  // Round-robin pick: first requester after last_grant, wrapping; nothing in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (reset_n) begin
      for (int unsigned k = 1; k <= nPorts; k++) begin
        cand = IdxWidth'((32'(last_grant) + k) % nPorts);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    gnt = gnt_any ? (nPorts'(1) << gnt_idx) : '0;
  end

  // Steer the winning port's request onto the RAM.
  always_comb begin
    sel_addr = addr[gnt_idx*aWidth +: aWidth];
    sel_d    = d[gnt_idx*dWidth +: dWidth];
    sel_be   = be[gnt_idx*BeWidth +: BeWidth];
    sel_we   = we[gnt_idx];
    wr_en    = gnt_any & sel_we;
    rd_en    = gnt_any & ~sel_we;
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (sel_be[b]) begin
          mem[sel_addr][b*8 +: 8] <= sel_d[b*8 +: 8];
        end
      end
    end
  end

  // First read stage carries data plus the owning port tag; reset drops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data    <= '0;
      rd_tag     <= '0;
      last_grant <= IdxWidth'(nPorts - 1);
    end else begin
      rd_tag <= rd_en ? gnt : '0;
      if (rd_en) begin
        rd_data <= mem[sel_addr];
      end
      if (gnt_any) begin
        last_grant <= gnt_idx;
      end
    end
  end

  if (outReg != 0) begin : g_out_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q      <= '0;
        rvalid <= '0;
      end else begin
        rvalid <= rd_tag;
        if (|rd_tag) begin
          q <= rd_data;
        end
      end
    end
  end else begin : g_no_out_reg
    assign q      = rd_data;
    assign rvalid = rd_tag;
  end

endmodule

// File: tb/tb_spram_arb.sv
// Directed bench for spram_arb: table of vectors on a 2-port/outReg=0 instance,
// plus hand sequences for 3-port rotation, outReg=1 pipelining and mid-read reset.
module tb_spram_arb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A: nPorts=2, outReg=0
  logic [1:0]  a_req, a_we, a_gnt, a_rv;
  logic [19:0] a_addr;
  logic [31:0] a_d;
  logic [3:0]  a_be;
  logic [15:0] a_q;

  // Instance B: nPorts=2, outReg=1
  logic [1:0]  b_req, b_we, b_gnt, b_rv;
  logic [19:0] b_addr;
  logic [31:0] b_d;
  logic [3:0]  b_be;
  logic [15:0] b_q;

  // Instance C: nPorts=3, outReg=0
  logic [2:0]  c_req, c_we, c_gnt, c_rv;
  logic [29:0] c_addr;
  logic [47:0] c_d;
  logic [5:0]  c_be;
  logic [15:0] c_q;

  spram_arb #(.aWidth(10), .dWidth(16), .nPorts(2), .outReg(0)) u_a (
    .clk(clk), .reset_n(reset_n), .req(a_req), .we(a_we), .addr(a_addr),
    .d(a_d), .be(a_be), .gnt(a_gnt), .q(a_q), .rvalid(a_rv));

  spram_arb #(.aWidth(10), .dWidth(16), .nPorts(2), .outReg(1)) u_b (
    .clk(clk), .reset_n(reset_n), .req(b_req), .we(b_we), .addr(b_addr),
    .d(b_d), .be(b_be), .gnt(b_gnt), .q(b_q), .rvalid(b_rv));

  spram_arb #(.aWidth(10), .dWidth(16), .nPorts(3), .outReg(0)) u_c (
    .clk(clk), .reset_n(reset_n), .req(c_req), .we(c_we), .addr(c_addr),
    .d(c_d), .be(c_be), .gnt(c_gnt), .q(c_q), .rvalid(c_rv));

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  be0;
    logic [1:0]  be1;
    logic [1:0]  gnt;
    logic [15:0] q;
    logic [1:0]  rv;
  } vec_t;

  vec_t       tbl [20];
  logic [2:0] c_exp [6];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {req, we, a0, a1, d0, d1, be0, be1, gnt, q, rv}; q/rv reflect the previous edge
    tbl[0]  = '{2'b00, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b00};
    tbl[1]  = '{2'b01, 2'b01, 10'h005, 10'h000, 16'hBEEF, 16'h0000, 2'b11, 2'b00, 2'b01, 16'h0000, 2'b00};
    tbl[2]  = '{2'b01, 2'b00, 10'h005, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h0000, 2'b00};
    tbl[3]  = '{2'b00, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'hBEEF, 2'b01};
    tbl[4]  = '{2'b01, 2'b01, 10'h010, 10'h000, 16'h1234, 16'h0000, 2'b11, 2'b00, 2'b01, 16'hBEEF, 2'b00};
    tbl[5]  = '{2'b01, 2'b01, 10'h010, 10'h000, 16'hAB55, 16'h0000, 2'b01, 2'b00, 2'b01, 16'hBEEF, 2'b00};
    tbl[6]  = '{2'b01, 2'b00, 10'h010, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'hBEEF, 2'b00};
    tbl[7]  = '{2'b00, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h1255, 2'b01};
    tbl[8]  = '{2'b10, 2'b10, 10'h000, 10'h030, 16'h0000, 16'h7777, 2'b00, 2'b11, 2'b10, 16'h1255, 2'b00};
    tbl[9]  = '{2'b01, 2'b01, 10'h030, 10'h000, 16'h1111, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h1255, 2'b00};
    tbl[10] = '{2'b10, 2'b00, 10'h000, 10'h030, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 16'h1255, 2'b00};
    tbl[11] = '{2'b11, 2'b00, 10'h005, 10'h010, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h7777, 2'b10};
    tbl[12] = '{2'b10, 2'b00, 10'h000, 10'h010, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 16'hBEEF, 2'b01};
    tbl[13] = '{2'b11, 2'b00, 10'h005, 10'h030, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h1255, 2'b10};
    tbl[14] = '{2'b11, 2'b00, 10'h010, 10'h030, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 16'hBEEF, 2'b01};
    tbl[15] = '{2'b01, 2'b00, 10'h010, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h7777, 2'b10};
    tbl[16] = '{2'b01, 2'b00, 10'h005, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h1255, 2'b01};
    tbl[17] = '{2'b01, 2'b00, 10'h030, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'hBEEF, 2'b01};
    tbl[18] = '{2'b00, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h7777, 2'b01};
    tbl[19] = '{2'b00, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h7777, 2'b00};

    c_exp[0] = 3'b001; c_exp[1] = 3'b010; c_exp[2] = 3'b100;
    c_exp[3] = 3'b001; c_exp[4] = 3'b010; c_exp[5] = 3'b100;

    reset_n = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_d = '0; a_be = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_d = '0; b_be = '0;
    c_req = 3'b111; c_we = 3'b111; c_addr = '0; c_d = '0; c_be = '1;

    // Reset state, with C requesting to show no grant leaks out during reset
    @(negedge clk);
    check("rst c_gnt", 32'(c_gnt), 32'h0);
    check("rst a_q", 32'(a_q), 32'h0);
    check("rst a_rv", 32'(a_rv), 32'h0);
    check("rst b_q", 32'(b_q), 32'h0);
    check("rst b_rv", 32'(b_rv), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Three ports all requesting: strict rotation starting at port 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("c rot%0d gnt", i), 32'(c_gnt), 32'(c_exp[i]));
      check($sformatf("c rot%0d rv", i), 32'(c_rv), 32'h0);
    end
    @(posedge clk); #1;
    c_req = '0;
    @(negedge clk);
    check("c q after writes", 32'(c_q), 32'h0);

    // Table-driven vectors on instance A
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      a_req  = tbl[i].req;
      a_we   = tbl[i].we;
      a_addr = {tbl[i].a1, tbl[i].a0};
      a_d    = {tbl[i].d1, tbl[i].d0};
      a_be   = {tbl[i].be1, tbl[i].be0};
      @(negedge clk);
      check($sformatf("v%0d gnt", i), 32'(a_gnt), 32'(tbl[i].gnt));
      check($sformatf("v%0d q", i), 32'(a_q), 32'(tbl[i].q));
      check($sformatf("v%0d rv", i), 32'(a_rv), 32'(tbl[i].rv));
    end

    // Instance B: preload then two back-to-back reads through the output stage
    @(posedge clk); #1;
    b_req = 2'b01; b_we = 2'b01; b_addr = {10'h000, 10'h020}; b_d = {16'h0, 16'h00AA}; b_be = 4'b0011;
    @(posedge clk); #1;
    b_addr = {10'h000, 10'h021}; b_d = {16'h0, 16'h00BB};
    @(posedge clk); #1;
    b_req = 2'b10; b_we = 2'b00; b_addr = {10'h020, 10'h000}; b_be = '0;
    @(negedge clk);
    check("b rd1 gnt", 32'(b_gnt), 32'h2);
    check("b rd1 rv", 32'(b_rv), 32'h0);
    @(posedge clk); #1;
    b_req = 2'b01; b_addr = {10'h000, 10'h021};
    @(negedge clk);
    check("b rd2 gnt", 32'(b_gnt), 32'h1);
    check("b g+1 rv", 32'(b_rv), 32'h0);
    check("b g+1 q", 32'(b_q), 32'h0);
    @(posedge clk); #1;
    b_req = 2'b00;
    @(negedge clk);
    check("b rd1 rv", 32'(b_rv), 32'h2);
    check("b rd1 q", 32'(b_q), 32'h00AA);
    @(negedge clk);
    check("b rd2 rv", 32'(b_rv), 32'h1);
    check("b rd2 q", 32'(b_q), 32'h00BB);
    @(negedge clk);
    check("b idle rv", 32'(b_rv), 32'h0);
    check("b hold q", 32'(b_q), 32'h00BB);

    // Reset pulse while B has a read in flight and A holds requests
    @(posedge clk); #1;
    b_req = 2'b01; b_we = 2'b00; b_addr = {10'h000, 10'h020};
    a_req = 2'b10; a_we = 2'b00; a_addr = {10'h010, 10'h000};
    @(negedge clk);
    check("pre-rst b gnt", 32'(b_gnt), 32'h1);
    check("pre-rst a gnt", 32'(a_gnt), 32'h2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    b_req = 2'b00;
    a_req = 2'b11; a_addr = {10'h010, 10'h005};
    #2;
    check("in-rst a gnt", 32'(a_gnt), 32'h0);
    check("in-rst a q", 32'(a_q), 32'h0);
    check("in-rst a rv", 32'(a_rv), 32'h0);
    check("in-rst b q", 32'(b_q), 32'h0);
    check("in-rst b rv", 32'(b_rv), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post-rst a gnt", 32'(a_gnt), 32'h1);
    @(posedge clk); #1;
    a_req = 2'b00;
    @(negedge clk);
    check("post-rst a rv", 32'(a_rv), 32'h1);
    check("post-rst a q", 32'(a_q), 32'hBEEF);
    check("post-rst b rv", 32'(b_rv), 32'h0);
    check("post-rst b q", 32'(b_q), 32'h0);
    @(negedge clk);
    check("post-rst b rv2", 32'(b_rv), 32'h0);
    check("post-rst a rv2", 32'(a_rv), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_arb.md
SPRAM_ARB -- requirements
Module: spram_arb

Interface
REQ-001 SHALL have parameter aWidth, default 10, address width per port.
REQ-002 SHALL have parameter dWidth, default 16, data width; legal values are multiples of 8.
REQ-003 SHALL have parameter nPorts, default 2, number of requesting channels; legal range 2..4.
REQ-004 SHALL have parameter outReg, default 0; a value of 1 adds an output register stage.
REQ-005 SHALL have parameter rStyle, default "no_rw_check"; it is used only as the RAM style attribute.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port req, input, nPorts bits: per-port access request.
REQ-009 SHALL have port we, input, nPorts bits: per-port write enable (1 = write, 0 = read).
REQ-010 SHALL have port addr, input, nPorts*aWidth bits: packed per-port address, with port i at slice [i*aWidth +: aWidth].
REQ-011 SHALL have port d, input, nPorts*dWidth bits: packed per-port write data.
REQ-012 SHALL have port be, input, nPorts*(dWidth/8) bits: packed per-port byte enables.
REQ-013 SHALL have port gnt, output, nPorts bits: one-hot grant, combinational.
REQ-014 SHALL have port q, output, dWidth bits: shared read data.
REQ-015 SHALL have port rvalid, output, nPorts bits: one-hot qualifier marking which port owns q.

Function
REQ-016 SHALL hold a 2^aWidth x dWidth array; array contents are not reset.
REQ-017 SHALL perform at most one access per clk edge, for the port i that has gnt[i]=1.
REQ-018 SHALL assert gnt only for ports with req=1, never for more than one port at a time, and never while reset_n=0.
REQ-019 SHALL arbitrate round-robin: search starts at last_grant+1 modulo nPorts; last_grant updates on every edge with a grant.
REQ-020 SHALL treat a request as consumed on the edge where its gnt=1; the requester holds req, we, addr, d and be stable until that edge.
REQ-021 SHALL, on a granted write, update only the bytes with be[b]=1; with be all zero the grant is consumed and memory is unchanged.
REQ-022 SHALL NOT assert rvalid for writes, and SHALL leave q unchanged on writes.
REQ-023 SHALL, on a granted read, present q with rvalid[i]=1 for exactly one cycle:
- 1 cycle after the grant edge when outReg=0;
- 2 cycles after when outReg=1.
REQ-024 SHALL hold q at its last read value when rvalid=0.
REQ-025 SHALL return the new data when a read is granted on the edge immediately after a write to the same address.
REQ-026 SHALL sustain one read per cycle back-to-back; with outReg=1 the pipeline carries two reads in flight with per-stage port tags.
REQ-027 SHALL grant continuously to a sole requester without idle cycles.

Reset
REQ-028 SHALL, while reset_n=0, force q=0, rvalid=0, gnt=0 and last_grant=nPorts-1, so port 0 has first priority after reset.
REQ-029 SHALL discard any in-flight read when reset asserts mid-operation; no rvalid pulse is emitted for it after release.
REQ-030 SHALL permit the first grant on the first rising clk edge after reset_n deasserts.

Verification
REQ-031 SHALL cover this scenario: dWidth=16, port0 writes 0xBEEF at 0x005 with be=11, then port0 reads 0x005 -> q=0xBEEF with rvalid=01 one cycle after the read grant (outReg=0).
REQ-032 SHALL cover this scenario: write 0x1234 at 0x010, then write 0xAB55 at 0x010 with be=01, then read 0x010 -> q=0x1255.
REQ-033 SHALL cover this scenario: nPorts=3, all req held high for 6 cycles after reset -> gnt sequence 001,010,100,001,010,100.
REQ-034 SHALL cover this scenario: outReg=1, port1 reads 0x020 (holding 0x00AA) then port0 reads 0x021 (holding 0x00BB) on consecutive cycles -> rvalid=10 with q=0x00AA, then rvalid=01 with q=0x00BB, at grant+2 each.
REQ-035 SHALL cover this scenario: read granted, reset_n pulsed low for a half cycle before the data edge -> q=0, rvalid=0, no rvalid after release; next grant goes to port 0.
REQ-036 SHALL cover this scenario: port0 write with be=00 to 0x030 (holding 0x7777), then read 0x030 -> q=0x7777.
